// File: rtl/result_serializer_if.sv
// Parallel-load / serial-stream bundle for result_serializer.
// The master side is the serializer itself; the slave side loads
// words and sinks the chunk stream.
interface result_serializer_if #(
  parameter int unsigned DATA_WIDTH = 96,
  parameter int unsigned CHUNK      = 8
);
  localparam int unsigned NCHUNK = DATA_WIDTH / CHUNK;
  localparam int unsigned CW     = $clog2(NCHUNK + 1);

  logic                  load;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  load_ready;
  logic [CHUNK-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;
  logic                  done;
  logic [CW-1:0]         chunks_left;

  modport master (
    input  load, data_in, out_ready,
    output load_ready, out_data, out_valid, busy, done, chunks_left
  );

  modport slave (
    output load, data_in, out_ready,
    input  load_ready, out_data, out_valid, busy, done, chunks_left
  );
endinterface

// File: rtl/result_serializer.sv
// Parallel-to-serial converter: captures one DATA_WIDTH word on load and
// streams it MSB chunk first over valid/ready, then pulses done.
module result_serializer #(
  parameter int unsigned DATA_WIDTH = 96,
  parameter int unsigned CHUNK      = 8
) (
  input  logic                clock,
  input  logic                rst,
  result_serializer_if.master bus
);
  localparam int unsigned NCHUNK = DATA_WIDTH / CHUNK;
  localparam int unsigned CW     = $clog2(NCHUNK + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] shreg, shreg_next;
  logic [CW-1:0]         cnt, cnt_next;

  // State, shift register and chunk counter; synchronous reset discards any word in flight.
  always_ff @(posedge clock) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      shreg <= shreg_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: load in IDLE, shift on each handshake in SEND, one DONE cycle.
  // The last handshake also shifts, leaving shreg all-zero so out_data reads 0 outside SEND.
  always_comb begin
    state_next = state;
    shreg_next = shreg;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (bus.load) begin
          shreg_next = bus.data_in;
          cnt_next   = CW'(NCHUNK);
          state_next = SEND;
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          shreg_next = shreg << CHUNK;
          if (cnt == CW'(1)) begin
            cnt_next   = '0;
            state_next = DONE;
          end else begin
            cnt_next = cnt - CW'(1);
          end
        end
      end
      DONE: begin
        shreg_next = '0;
        cnt_next   = '0;
        state_next = IDLE;
      end
      default: begin
        shreg_next = '0;
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  assign bus.load_ready  = (state == IDLE);
  assign bus.out_valid   = (state == SEND);
  assign bus.busy        = (state == SEND) || (state == DONE);
  assign bus.done        = (state == DONE);
  assign bus.out_data    = shreg[DATA_WIDTH-1 -: CHUNK];
  assign bus.chunks_left = (state == SEND) ? cnt : '0;
endmodule

// File: tb/tb_result_serializer.sv
// Directed self-checking bench for result_serializer (96-bit word, 8-bit chunks).
module tb_result_serializer;
  localparam int DW  = 96;
  localparam int CK  = 8;
  localparam int NCH = DW / CK;
  localparam logic [DW-1:0] W_BASIC = 96'h0102_0304_0506_0708_090A_0B0C;

  logic clock = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  result_serializer_if #(.DATA_WIDTH(DW), .CHUNK(CK)) bus ();
  result_serializer #(.DATA_WIDTH(DW), .CHUNK(CK)) dut (
    .clock(clock),
    .rst  (rst),
    .bus  (bus)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [CK-1:0] chunk_of(input logic [DW-1:0] w, input int idx);
    return w[DW-1-CK*idx -: CK];
  endfunction

  task automatic test_reset;
    rst = 1'b1; bus.load = 1'b1; bus.data_in = '1; bus.out_ready = 1'b1;
    tick; tick;
    rst = 1'b0; bus.load = 1'b0; bus.data_in = '0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", bus.out_data); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.chunks_left !== 4'd0) begin errors++; $display("FAIL reset_chunks_left: got %0d want 0", bus.chunks_left); end
    checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready: got %b want 1", bus.load_ready); end
    tick;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_priority_over_load: out_valid got %b want 0", bus.out_valid); end
  endtask

  task automatic test_basic;
    bus.data_in = W_BASIC; bus.load = 1'b1; bus.out_ready = 1'b1;
    tick;
    bus.load = 1'b0; bus.data_in = '0;
    for (int i = 0; i < NCH; i++) begin
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d]: got %b want 1", i, bus.out_valid); end
      checks++; if (bus.out_data !== 8'(i + 1)) begin errors++; $display("FAIL basic_data[%0d]: got %h want %h", i, bus.out_data, 8'(i + 1)); end
      checks++; if (bus.chunks_left !== 4'(NCH - i)) begin errors++; $display("FAIL basic_chunks_left[%0d]: got %0d want %0d", i, bus.chunks_left, NCH - i); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_early_done[%0d]: got %b want 0", i, bus.done); end
      tick;
    end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", bus.done); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_done_busy: got %b want 1", bus.busy); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_done_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL basic_done_load_ready: got %b want 0", bus.load_ready); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL basic_done_data: got %h want 00", bus.out_data); end
    tick;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", bus.done); end
    checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL basic_idle_load_ready: got %b want 1", bus.load_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_backpressure;
    bus.data_in = W_BASIC; bus.load = 1'b1; bus.out_ready = 1'b0;
    tick;
    bus.load = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (i == 0 || i == 4 || i == NCH - 1) begin
        for (int s = 0; s < 3; s++) begin
          bus.out_ready = 1'b0;
          checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_stall_valid[%0d.%0d]: got %b want 1", i, s, bus.out_valid); end
          checks++; if (bus.out_data !== chunk_of(W_BASIC, i)) begin errors++; $display("FAIL bp_stall_data[%0d.%0d]: got %h want %h", i, s, bus.out_data, chunk_of(W_BASIC, i)); end
          checks++; if (bus.chunks_left !== 4'(NCH - i)) begin errors++; $display("FAIL bp_stall_left[%0d.%0d]: got %0d want %0d", i, s, bus.chunks_left, NCH - i); end
          tick;
        end
      end
      bus.out_ready = 1'b1;
      checks++; if (bus.out_data !== chunk_of(W_BASIC, i)) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", i, bus.out_data, chunk_of(W_BASIC, i)); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL bp_early_done[%0d]: got %b want 0", i, bus.done); end
      tick;
    end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b want 1", bus.done); end
    tick;
    checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL bp_load_ready: got %b want 1", bus.load_ready); end
  endtask

  task automatic test_load_busy;
    bus.data_in = W_BASIC; bus.load = 1'b1; bus.out_ready = 1'b1;
    tick;
    for (int i = 0; i < NCH; i++) begin
      bus.load    = (i == 3);
      bus.data_in = (i == 3) ? '1 : '0;
      checks++; if (bus.out_data !== chunk_of(W_BASIC, i)) begin errors++; $display("FAIL busy_load_data[%0d]: got %h want %h", i, bus.out_data, chunk_of(W_BASIC, i)); end
      tick;
    end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL busy_load_done: got %b want 1", bus.done); end
    bus.load = 1'b1; bus.data_in = '1;
    tick;
    bus.load = 1'b0; bus.data_in = '0;
    checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL busy_load_ready: got %b want 1", bus.load_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL busy_load_second_word: got %b want 0", bus.out_valid); end
    tick;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL busy_load_second_word_late: got %b want 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_load_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid;
    logic [DW-1:0] wa;
    wa = {NCH{8'hA5}};
    bus.data_in = W_BASIC; bus.load = 1'b1; bus.out_ready = 1'b1;
    tick;
    bus.load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.out_data !== chunk_of(W_BASIC, i)) begin errors++; $display("FAIL rst_mid_pre[%0d]: got %h want %h", i, bus.out_data, chunk_of(W_BASIC, i)); end
      tick;
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL rst_mid_data: got %h want 00", bus.out_data); end
    checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_load_ready: got %b want 1", bus.load_ready); end
    checks++; if (bus.chunks_left !== 4'd0) begin errors++; $display("FAIL rst_mid_left: got %0d want 0", bus.chunks_left); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_mid_done0: got %b want 0", bus.done); end
    for (int c = 0; c < 3; c++) begin
      tick;
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_mid_done[%0d]: got %b want 0", c, bus.done); end
    end
    bus.data_in = wa; bus.load = 1'b1;
    tick;
    bus.load = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      checks++; if (bus.out_data !== 8'hA5 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_a5[%0d]: got %h/%b want a5/1", i, bus.out_data, bus.out_valid); end
      tick;
    end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL rst_mid_a5_done: got %b want 1", bus.done); end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] words [3];
    int p, k;
    for (int j = 0; j < 3; j++) words[j] = {$urandom(), $urandom(), $urandom()};
    bus.out_ready = 1'b1; bus.load = 1'b1;
    for (int t = 0; t < 3 * (NCH + 2); t++) begin
      p = t % (NCH + 2);
      k = t / (NCH + 2);
      if (p == 0) begin
        checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL b2b_accept[%0d]: got %b want 1", k, bus.load_ready); end
        bus.data_in = words[k];
      end else if (p <= NCH) begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== chunk_of(words[k], p - 1)) begin errors++; $display("FAIL b2b_data[%0d.%0d]: got %h/%b want %h/1", k, p - 1, bus.out_data, bus.out_valid, chunk_of(words[k], p - 1)); end
        bus.data_in = {$urandom(), $urandom(), $urandom()};
      end else begin
        checks++; if (bus.done !== 1'b1 || bus.load_ready !== 1'b0) begin errors++; $display("FAIL b2b_done[%0d]: got done=%b load_ready=%b want 1/0", k, bus.done, bus.load_ready); end
      end
      tick;
    end
    bus.load = 1'b0; bus.data_in = '0;
    checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL b2b_final_idle: got %b want 1", bus.load_ready); end
  endtask

  task automatic test_round_trip;
    logic [DW-1:0] word, coll;
    logic rdy;
    int hs, c;
    for (int it = 0; it < 100; it++) begin
      word = {$urandom(), $urandom(), $urandom()};
      bus.data_in = word; bus.load = 1'b1;
      tick;
      bus.load = 1'b0;
      coll = '0; hs = 0; c = 0;
      while (bus.done !== 1'b1 && c < 200) begin
        rdy = 1'($urandom_range(0, 1));
        bus.out_ready = rdy;
        if (bus.out_valid === 1'b1 && rdy) begin
          coll = {coll[DW-CK-1:0], bus.out_data};
          hs++;
        end
        tick;
        c++;
      end
      bus.out_ready = 1'b1;
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL rt_timeout[%0d]: done got %b want 1", it, bus.done); end
      checks++; if (coll !== word) begin errors++; $display("FAIL rt_word[%0d]: got %h want %h", it, coll, word); end
      checks++; if (hs !== NCH) begin errors++; $display("FAIL rt_handshakes[%0d]: got %0d want %0d", it, hs, NCH); end
      tick;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; bus.load = 1'b0; bus.data_in = '0; bus.out_ready = 1'b0;
    test_reset;
    test_basic;
    test_backpressure;
    test_load_busy;
    test_reset_mid;
    test_back_to_back;
    test_round_trip;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
